// File: rtl/round_timer.sv
// Round countdown timer with hit scoring and a four-digit multiplexed
// seven-segment display (time_left on digits 0-1, score on digits 2-3).
module round_timer #(
    parameter int unsigned START_SECS = 10
) (
    input  logic       masterclk,
    input  logic       rst,
    input  logic       onehzclk,
    input  logic       fastclk,
    input  logic       start,
    input  logic       hit,
    output logic [6:0] time_left,
    output logic [6:0] score,
    output logic       expired,
    output logic [3:0] Anode_Activate,
    output logic [6:0] LED_out
);

    localparam logic [6:0] LP_START     = 7'(START_SECS);
    localparam logic [6:0] LP_SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EXPIRED
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_time_left;
    logic [6:0]  w_time_nxt;
    logic [6:0]  r_score;
    logic [6:0]  w_score_nxt;
    logic        r_expired;
    logic        r_onehz_prev;
    logic        r_fast_prev;
    logic        w_sec_tick;
    logic        w_refresh_tick;
    logic [1:0]  r_idx;
    logic [3:0]  r_anode;
    logic [6:0]  r_led;
    logic [3:0]  w_digit;
    logic [3:0]  w_anode_nxt;
    logic [6:0]  w_led_nxt;

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    // Edge detectors track their inputs even during reset, so the first
    // cycle after release never sees a stale low "previous" value.
    always_ff @(posedge masterclk) begin
        r_onehz_prev <= onehzclk;
        r_fast_prev  <= fastclk;
    end

    assign w_sec_tick     = onehzclk & ~r_onehz_prev;
    assign w_refresh_tick = fastclk  & ~r_fast_prev;

    always_ff @(posedge masterclk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_time_left <= LP_START;
            r_score     <= '0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time_left <= w_time_nxt;
            r_score     <= w_score_nxt;
            r_expired   <= (w_state_nxt == ST_EXPIRED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time_left;
        w_score_nxt = r_score;
        case (r_state)
            ST_IDLE: begin
                w_time_nxt  = LP_START;
                w_score_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A hit takes precedence over a coincident second tick.
                if (hit) begin
                    w_time_nxt  = LP_START;
                    w_score_nxt = (r_score >= LP_SCORE_MAX) ? LP_SCORE_MAX : r_score + 7'd1;
                end else if (w_sec_tick) begin
                    if (r_time_left <= 7'd1) begin
                        w_time_nxt  = '0;
                        w_state_nxt = ST_EXPIRED;
                    end else begin
                        w_time_nxt = r_time_left - 7'd1;
                    end
                end
            end
            ST_EXPIRED: begin
                w_time_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_time_nxt  = LP_START;
                    w_score_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_time_nxt  = LP_START;
                w_score_nxt = '0;
            end
        endcase
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_digit = bcd_ones(r_time_left);
            2'd1:    w_digit = bcd_tens(r_time_left);
            2'd2:    w_digit = bcd_ones(r_score);
            default: w_digit = bcd_tens(r_score);
        endcase
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_anode_nxt = 4'b1110;
            2'd1:    w_anode_nxt = 4'b1101;
            2'd2:    w_anode_nxt = 4'b1011;
            default: w_anode_nxt = 4'b0111;
        endcase
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_led_nxt = 7'b0000001;
            4'd1:    w_led_nxt = 7'b1001111;
            4'd2:    w_led_nxt = 7'b0010010;
            4'd3:    w_led_nxt = 7'b0000110;
            4'd4:    w_led_nxt = 7'b1001100;
            4'd5:    w_led_nxt = 7'b0100100;
            4'd6:    w_led_nxt = 7'b0100000;
            4'd7:    w_led_nxt = 7'b0001111;
            4'd8:    w_led_nxt = 7'b0000000;
            4'd9:    w_led_nxt = 7'b0000100;
            default: w_led_nxt = 7'b1111111;
        endcase
    end

    // Display refreshes in every state; outputs lag index/values by one cycle.
    always_ff @(posedge masterclk) begin
        if (rst) begin
            r_idx   <= '0;
            r_anode <= '1;
            r_led   <= '1;
        end else begin
            r_idx   <= r_idx + {1'b0, w_refresh_tick};
            r_anode <= w_anode_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign time_left      = r_time_left;
    assign score          = r_score;
    assign expired        = r_expired;
    assign Anode_Activate = r_anode;
    assign LED_out        = r_led;

endmodule

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: the driver pushes expected post-edge
// outputs from a behavioural model; a monitor pops and compares each cycle.
module tb_round_timer;

    localparam int unsigned S = 3;

    logic       masterclk = 1'b0;
    logic       rst = 1'b1;
    logic       onehzclk = 1'b0;
    logic       fastclk = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [6:0] time_left;
    logic [6:0] score;
    logic       expired;
    logic [3:0] Anode_Activate;
    logic [6:0] LED_out;

    round_timer #(.START_SECS(S)) dut (
        .masterclk      (masterclk),
        .rst            (rst),
        .onehzclk       (onehzclk),
        .fastclk        (fastclk),
        .start          (start),
        .hit            (hit),
        .time_left      (time_left),
        .score          (score),
        .expired        (expired),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out)
    );

    always #5 masterclk = ~masterclk;

    typedef struct {
        int    tl;
        int    sc;
        int    ex;
        int    an;
        int    led;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    // Behavioural model: game phase as two flags, plain integer arithmetic.
    bit   m_running = 0;
    bit   m_over    = 0;
    int   m_tl      = S;
    int   m_sc      = 0;
    int   m_idx     = 0;
    logic m_p1      = 1'b0;
    logic m_pf      = 1'b0;

    logic lo = 1'b0;
    logic lf = 1'b0;

    task automatic chk(input string nm, input string tag, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s [%s] t=%0t actual=%0h expected=%0h", nm, tag, $time, act, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic o, input logic f, input logic s, input logic h, input string tag);
        exp_t e;
        bit   sec;
        bit   rf;
        int   d;
        @(negedge masterclk);
        rst = r; onehzclk = o; fastclk = f; start = s; hit = h;
        sec  = (o === 1'b1) && (m_p1 !== 1'b1);
        rf   = (f === 1'b1) && (m_pf !== 1'b1);
        m_p1 = o;
        m_pf = f;
        if (r) begin
            m_running = 0; m_over = 0; m_tl = S; m_sc = 0; m_idx = 0;
            e.an = 15; e.led = 127;
        end else begin
            case (m_idx)
                0:       d = m_tl % 10;
                1:       d = m_tl / 10;
                2:       d = m_sc % 10;
                default: d = m_sc / 10;
            endcase
            e.an  = 15 & ~(1 << m_idx);
            e.led = int'(seg_tab[d]);
            m_idx = (m_idx + (rf ? 1 : 0)) % 4;
            if (m_over) begin
                if (s) begin
                    m_over = 0; m_running = 1; m_tl = S; m_sc = 0;
                end
            end else if (m_running) begin
                if (h) begin
                    m_tl = S;
                    if (m_sc < 99) m_sc++;
                end else if (sec) begin
                    m_tl--;
                    if (m_tl == 0) begin
                        m_running = 0; m_over = 1;
                    end
                end
            end else if (s) begin
                m_running = 1;
            end
        end
        e.tl = m_tl; e.sc = m_sc; e.ex = m_over ? 1 : 0; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic step(input logic s, input logic h, input string tag);
        cyc(1'b0, lo, lf, s, h, tag);
    endtask

    task automatic sec_tick(input string tag);
        lo = 1'b1; step(1'b0, 1'b0, tag);
        step(1'b0, 1'b0, tag);
        lo = 1'b0; step(1'b0, 1'b0, tag);
        step(1'b0, 1'b0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge masterclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("time_left", e.tag, 32'(time_left), e.tl);
                chk("score", e.tag, 32'(score), e.sc);
                chk("expired", e.tag, 32'(expired), e.ex);
                chk("anode", e.tag, 32'(Anode_Activate), e.an);
                chk("led", e.tag, 32'(LED_out), e.led);
            end
        end
    end

    initial begin : driver
        int ho;
        int hf;
        repeat (3) cyc(1'b1, lo, lf, 1'b0, 1'b0, "reset");

        step(1'b0, 1'b0, "idle");
        step(1'b0, 1'b1, "idle_hit_ignored");
        step(1'b1, 1'b0, "start");
        repeat (3) sec_tick("countdown");
        step(1'b0, 1'b1, "expired_hit_ignored");
        sec_tick("expired_tick_ignored");
        step(1'b1, 1'b0, "restart");
        step(1'b0, 1'b0, "restart_hold");

        sec_tick("to2");
        sec_tick("to1");
        lo = 1'b1; step(1'b0, 1'b1, "hit_vs_tick_at1");
        step(1'b1, 1'b0, "start_in_run_ignored");
        lo = 1'b0; step(1'b0, 1'b0, "after_hit");

        for (int i = 0; i < 100; i++) begin
            lf = ~lf;
            step(1'b0, 1'b1, "sat_hits");
            lf = ~lf;
            step(1'b0, 1'b0, "sat_gap");
        end
        repeat (16) begin
            lf = ~lf;
            step(1'b0, 1'b0, "score99_display");
        end

        lf = 1'b0;
        cyc(1'b1, lo, lf, 1'b0, 1'b0, "reset2");
        step(1'b1, 1'b0, "start2");
        repeat (12) step(1'b0, 1'b1, "hits12");
        repeat (16) begin
            lf = ~lf;
            step(1'b0, 1'b0, "scan_3_12");
        end

        lf = 1'b0;
        cyc(1'b1, lo, lf, 1'b0, 1'b0, "reset3");
        step(1'b1, 1'b0, "start3");
        lo = 1'b1; step(1'b0, 1'b0, "tick_to2");
        step(1'b0, 1'b0, "hold_high");
        cyc(1'b1, lo, lf, 1'b1, 1'b1, "rst_prio");
        cyc(1'b1, lo, lf, 1'b0, 1'b0, "rst_high_hz");
        step(1'b1, 1'b0, "release_start");
        repeat (4) step(1'b0, 1'b0, "no_spurious_tick");
        lo = 1'b0; step(1'b0, 1'b0, "low");

        ho = 0;
        hf = 0;
        for (int i = 0; i < 4000; i++) begin
            if (ho == 0) begin lo = ~lo; ho = $urandom_range(1, 6); end else ho--;
            if (hf == 0) begin lf = ~lf; hf = $urandom_range(0, 2); end else hf--;
            cyc(logic'($urandom_range(0, 299) == 0), lo, lf,
                logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 5) == 0), "random");
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge masterclk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter START_SECS, default 10, round length in seconds; legal range 1..99.
REQ-002 masterclk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 onehzclk  input  1  1 Hz square wave from the clock divider, synchronous to masterclk; each rising edge is one second tick.
REQ-005 fastclk  input  1  display-refresh square wave from the clock divider, synchronous to masterclk; each rising edge is one digit advance.
REQ-006 start  input  1  single-cycle pulse that begins a round.
REQ-007 hit  input  1  single-cycle pulse for a correct player action.
REQ-008 time_left  output  7  remaining seconds, binary, 0..99.
REQ-009 score  output  7  correct actions this game, binary, 0..99.
REQ-010 expired  output  1  high while in EXPIRED.
REQ-011 Anode_Activate  output  4  active-low one-hot digit select.
REQ-012 LED_out  output  7  active-low segments; bit6=a through bit0=g.

Function
REQ-013 Tick detection: sec_tick SHALL be onehzclk & ~onehz_prev, and refresh_tick SHALL be fastclk & ~fast_prev; each prev register samples its input every cycle.
REQ-014 Each tick SHALL be exactly one masterclk cycle wide per input rising edge; a steady-high input SHALL produce no further ticks.
REQ-015 FSM states: IDLE, RUN, EXPIRED.
REQ-016 IDLE: time_left=START_SECS and score=0; start moves to RUN on the next edge; hit and sec_tick are ignored.
REQ-017 RUN, sec_tick without hit: time_left decrements by 1 on the next edge; if time_left was 1, it becomes 0 and the state moves to EXPIRED on the same edge.
REQ-018 RUN, hit: time_left reloads to START_SECS and score increments by 1, saturating at 99; a simultaneous sec_tick is discarded (hit wins, including when time_left=1).
REQ-019 RUN: start is ignored.
REQ-020 EXPIRED: expired=1; time_left holds 0; score holds; hit and sec_tick are ignored.
REQ-021 EXPIRED, start: move to RUN with time_left=START_SECS and score=0 on the same edge.
REQ-022 expired SHALL be a registered output, high exactly in the cycles where the state is EXPIRED.
REQ-023 Display index: a 2-bit counter advances on refresh_tick and wraps 3->0.
REQ-024 Digit mapping: idx0 = time_left ones, idx1 = time_left tens, idx2 = score ones, idx3 = score tens.
REQ-025 BCD conversion: tens = v/10 and ones = v%10, for v<=99.
REQ-026 Anode_Activate: idx0->1110, idx1->1101, idx2->1011, idx3->0111.
REQ-027 LED_out encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-028 Anode_Activate and LED_out SHALL be registered, reflecting index and values one cycle after they change.
REQ-029 The display SHALL refresh continuously in every FSM state.

Reset
REQ-030 rst high SHALL force: state=IDLE, time_left=START_SECS, score=0, expired=0, index=0, Anode_Activate=1111, LED_out=1111111.
REQ-031 During rst, onehz_prev and fast_prev SHALL load their current input values, so no spurious tick occurs in the first cycle after reset.
REQ-032 rst SHALL take priority over start, hit and ticks in the same cycle.
REQ-033 rst asserted mid-round SHALL abandon the round with no residual tick or score.

Verification (bench with START_SECS=3)
REQ-034 Reset release, then start, then 3 onehzclk rising edges -> time_left steps 3,2,1,0; expired rises on the third tick edge.
REQ-035 In RUN at time_left=1, hit coincident with sec_tick -> time_left=3, score=1, still RUN, expired=0.
REQ-036 100 hits in RUN -> score saturates at 99; score-tens digit shows 1001100 (4) ... final digits show 9 and 9 (0000100).
REQ-037 In EXPIRED, apply hit then start -> hit ignored; after start: RUN, time_left=3, score=0, expired=0.
REQ-038 8 fastclk rising edges with time_left=3, score=12 -> Anode_Activate cycles 1110,1101,1011,0111 twice; LED_out = 0000110, 0000001, 0010010, 1001111.
REQ-039 rst asserted while onehzclk is high and RUN at time_left=2 -> all REQ-030 values; no tick in the cycle after release.
